// File: rtl/cpu_sequencer.sv
// Microcode sequencer for the 8-bit SAP-style CPU.
// Ports: clk, rst_n, run, step, opcode, cf, zf in; ctrl[14:0], t_state[2:0], halted out.
module cpu_sequencer #(
  parameter int CTRL_W        = 15,
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic [3:0]        opcode,
  input  logic              cf,
  input  logic              zf,
  output logic [CTRL_W-1:0] ctrl,
  output logic [2:0]        t_state,
  output logic              halted
);

  typedef enum logic [2:0] {
    T0  = 3'd0,
    T1  = 3'd1,
    T2  = 3'd2,
    T3  = 3'd3,
    T4  = 3'd4,
    T5  = 3'd5,
    HLT = 3'd7
  } state_e;

  localparam logic [CTRL_W-1:0] IDLE   = 15'h0FE3;
  localparam logic [CTRL_W-1:0] F_T0   = 15'h27E3;
  localparam logic [CTRL_W-1:0] F_T1   = 15'h4FE3;
  localparam logic [CTRL_W-1:0] F_T2   = 15'h0D63;
  localparam logic [CTRL_W-1:0] EI_LMA = 15'h07A3;
  localparam logic [CTRL_W-1:0] CE_LA  = 15'h0DC3;
  localparam logic [CTRL_W-1:0] CE_LB  = 15'h0DE1;
  localparam logic [CTRL_W-1:0] CE_LBS = 15'h0DE9;
  localparam logic [CTRL_W-1:0] EU_LA  = 15'h0FC7;
  localparam logic [CTRL_W-1:0] EU_LAS = 15'h0FCF;
  localparam logic [CTRL_W-1:0] EA_LMD = 15'h0BF3;
  localparam logic [CTRL_W-1:0] RAM_WR = 15'h0EE3;
  localparam logic [CTRL_W-1:0] EI_LA  = 15'h0F83;
  localparam logic [CTRL_W-1:0] EI_LP  = 15'h1FA3;
  localparam logic [CTRL_W-1:0] EA_LO  = 15'h0FF2;

  state_e            state_q;
  state_e            state_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic              go;

  assign go = run | step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= T0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl_d  = IDLE;
    unique case (state_q)
      T0: begin
        if (go) begin
          ctrl_d  = F_T0;
          state_d = T1;
        end
      end
      T1: begin
        ctrl_d  = F_T1;
        state_d = T2;
      end
      T2: begin
        ctrl_d  = F_T2;
        state_d = T3;
      end
      T3: begin
        state_d = T0;
        case (opcode)
          4'h0: ;
          4'h1, 4'h2, 4'h3, 4'h4: begin
            ctrl_d  = EI_LMA;
            state_d = T4;
          end
          4'h5: ctrl_d = EI_LA;
          4'h6: ctrl_d = EI_LP;
          4'h7: if (cf) ctrl_d = EI_LP;
          4'h8: if (zf) ctrl_d = EI_LP;
          4'hE: ctrl_d = EA_LO;
          4'hF: state_d = HLT;
          default: if (HALT_ON_UNDEF) state_d = HLT;
        endcase
      end
      T4: begin
        state_d = T0;
        case (opcode)
          4'h1: ctrl_d = CE_LA;
          4'h2: begin
            ctrl_d  = CE_LB;
            state_d = T5;
          end
          4'h3: begin
            ctrl_d  = CE_LBS;
            state_d = T5;
          end
          4'h4: begin
            ctrl_d  = EA_LMD;
            state_d = T5;
          end
          default: ;
        endcase
      end
      T5: begin
        state_d = T0;
        case (opcode)
          4'h2:    ctrl_d = EU_LA;
          4'h3:    ctrl_d = EU_LAS;
          4'h4:    ctrl_d = RAM_WR;
          default: ;
        endcase
      end
      HLT: state_d = HLT;
      default: state_d = T0;
    endcase
  end

  // Reset forces IDLE immediately, even mid-cycle.
  assign ctrl    = rst_n ? ctrl_d : IDLE;
  assign t_state = state_q;
  assign halted  = (state_q == HLT);

endmodule
